fxu_reservation_station: RTL

Four-entry reservation station for one fixed-point unit, directly downstream of the instruction buffer. Accepts one renamed instruction per cycle with its operand values, or the ROB owner tags of operands still pending. Captures pending operands from the common data bus (CDB). Issues the oldest fully-ready entry to the FXU over a valid/ready handshake. Its `full` output drives the buffer's `fxu_0_full` / `fxu_1_full` inputs.

---
 rtl/fxu_reservation_station.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fxu_reservation_station.sv
// Four-entry reservation station for the fixed-point unit: CDB operand capture, age-matrix oldest-ready select.
// Define RS_WAKEUP_BYPASS_EN to let a CDB broadcast make an entry issuable in the same cycle.
module fxu_reservation_station #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_opcode,
  input  logic                      disp_a_valid,
  input  logic [DATA_W-1:0]         disp_a_value,
  input  logic [TAG_W-1:0]          disp_a_owner,
  input  logic                      disp_b_valid,
  input  logic [DATA_W-1:0]         disp_b_value,
  input  logic [TAG_W-1:0]          disp_b_owner,
  input  logic [TAG_W-1:0]          disp_rt,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_value,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_opcode,
  output logic [DATA_W-1:0]         iss_a,
  output logic [DATA_W-1:0]         iss_b,
  output logic [TAG_W-1:0]          iss_rt,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [TAG_W-1:0]  rt_q [DEPTH];
  logic [DEPTH-1:0]  av_q, bv_q;
  logic [DATA_W-1:0] a_q [DEPTH];
  logic [DATA_W-1:0] b_q [DEPTH];
  logic [TAG_W-1:0]  ao_q [DEPTH];
  logic [TAG_W-1:0]  bo_q [DEPTH];

  logic [DEPTH-1:0]  a_wake, b_wake, a_rdy, b_rdy, ready, sel;
  logic [DATA_W-1:0] a_val [DEPTH];
  logic [DATA_W-1:0] b_val [DEPTH];
  logic [IW-1:0]     widx;
  logic              disp_fire, iss_fire, a_cap, b_cap;

  assign disp_ready = (count_q < CW'(DEPTH));
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign iss_fire   = iss_valid & iss_ready;
  assign a_cap      = ~disp_a_valid & cdb_valid & (disp_a_owner == cdb_tag);
  assign b_cap      = ~disp_b_valid & cdb_valid & (disp_b_owner == cdb_tag);

  always_comb begin
    a_wake = '0;
    b_wake = '0;
    a_rdy  = '0;
    b_rdy  = '0;
    ready  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      a_wake[i] = cdb_valid & busy_q[i] & ~av_q[i] & (ao_q[i] == cdb_tag);
      b_wake[i] = cdb_valid & busy_q[i] & ~bv_q[i] & (bo_q[i] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      a_rdy[i] = av_q[i] | a_wake[i];
      b_rdy[i] = bv_q[i] | b_wake[i];
      a_val[i] = av_q[i] ? a_q[i] : cdb_value;
      b_val[i] = bv_q[i] ? b_q[i] : cdb_value;
`else
      a_rdy[i] = av_q[i];
      b_rdy[i] = bv_q[i];
      a_val[i] = a_q[i];
      b_val[i] = b_q[i];
`endif
      ready[i] = busy_q[i] & a_rdy[i] & b_rdy[i];
    end
  end

  // older_q[j][i] set means entry j was dispatched before entry i
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int unsigned j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older_q[j][i]) sel[i] = 1'b0;
    end
  end

  always_comb begin
    iss_valid  = |ready;
    iss_opcode = '0;
    iss_a      = '0;
    iss_b      = '0;
    iss_rt     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss_opcode = iss_opcode | op_q[i];
        iss_a      = iss_a | a_val[i];
        iss_b      = iss_b | b_val[i];
        iss_rt     = iss_rt | rt_q[i];
      end
    end
  end

  always_comb begin
    widx = '0;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (!busy_q[i-1]) widx = IW'(i-1);
    older_d = older_q;
    busy_d  = busy_q;
    if (iss_fire) busy_d = busy_d & ~sel;
    if (disp_fire) begin
      busy_d[widx] = 1'b1;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        older_d[j][widx] = busy_q[j];
        older_d[widx][j] = 1'b0;
      end
    end
    count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
      av_q    <= '0;
      bv_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older_q[i] <= '0;
        op_q[i]    <= '0;
        rt_q[i]    <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        ao_q[i]    <= '0;
        bo_q[i]    <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      older_q <= older_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (a_wake[i]) begin
          av_q[i] <= 1'b1;
          a_q[i]  <= cdb_value;
        end
        if (b_wake[i]) begin
          bv_q[i] <= 1'b1;
          b_q[i]  <= cdb_value;
        end
      end
      // widx is never busy, so this cannot collide with the wakeup writes above
      if (disp_fire) begin
        op_q[widx] <= disp_opcode;
        rt_q[widx] <= disp_rt;
        av_q[widx] <= disp_a_valid | a_cap;
        bv_q[widx] <= disp_b_valid | b_cap;
        a_q[widx]  <= a_cap ? cdb_value : disp_a_value;
        b_q[widx]  <= b_cap ? cdb_value : disp_b_value;
        ao_q[widx] <= disp_a_owner;
        bo_q[widx] <= disp_b_owner;
      end
    end
  end

endmodule
